// File: rtl/pe_ld_pkg.sv
// Shared types and default widths for the PE load unit, memory side.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pe_ld_pkg;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_REQ   = 2'd1,
    LD_STALL = 2'd2
  } ld_state_t;

  localparam int LD_DATA_W = 32;
  localparam int LD_ADDR_W = 16;

endpackage

// File: rtl/pe_ld_rsp_fifo.sv
// Response buffer: DEPTH x DATA_W synchronous FIFO, head word always visible on pop_data.
// Latency: a pushed word is visible on pop_data the cycle after the push (no bypass).
// Backpressure: a push while full is taken only if a pop happens in the same cycle.
// Ports: clk, rst (sync, active-low); push/push_data in; pop in; pop_data, full, empty, count out.
module pe_ld_rsp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [PW-1:0]     count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rd_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit; the low bits index the storage.
  assign wr_idx = IW'(wr_ptr % PW'(DEPTH));
  assign rd_idx = IW'(rd_ptr % PW'(DEPTH));

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_idx == rd_idx);
  assign count = wr_ptr - rd_ptr;

  // Empty buffer shows zero rather than a stale word.
  assign pop_data = empty ? '0 : mem[rd_idx];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pe_ld_unit_mem_side.sv
// Memory-side load unit: takes load addresses, issues in-order reads on req/gnt, buffers
// returned words for the functional unit. Latency: accept t -> req t+1 -> rsp t+1+L -> rdy t+2+L.
// Backpressure: at most DEPTH loads requested+buffered; a further load waits in STALL.
// Ports: instr_ld_valid/addr/rdy (decode side), mem_req/addr/gnt and mem_rsp_valid/data
// (memory side), memory_unit_rdy/ld_data/func_unit_rdy (functional unit side).
// Optional macro PE_LD_UNIT_PERF_CNT_EN adds saturating gnt_stall_cnt and fu_stall_cnt outputs.
module pe_ld_unit_mem_side
  import pe_ld_pkg::*;
#(
  parameter int DATA_W = LD_DATA_W,
  parameter int ADDR_W = LD_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_ld_valid,
  input  logic [ADDR_W-1:0] instr_ld_addr,
  output logic              instr_ld_rdy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              memory_unit_rdy,
  output logic [DATA_W-1:0] ld_data,
  input  logic              func_unit_rdy
`ifdef PE_LD_UNIT_PERF_CNT_EN
  ,
  output logic [31:0]       gnt_stall_cnt,
  output logic [31:0]       fu_stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;

  ld_state_t         state_q;
  ld_state_t         state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     outstanding_q;
  logic [CW-1:0]     fifo_count;
  logic [UW-1:0]     used;
  logic [UW-1:0]     used_eff;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              gnt_fire;
  logic              rsp_ok;
  logic              credit_ok;
  logic              credit_after_gnt;
  logic              rdy_int;
  logic              req_int;
  logic              load_addr;

  assign used     = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign pop      = func_unit_rdy & ~fifo_empty;
  // A word leaving the buffer this cycle frees its slot for the decision made this cycle.
  assign used_eff = used - UW'(pop);

  assign credit_ok        = used_eff < UW'(DEPTH);
  assign credit_after_gnt = (used_eff + UW'(1)) < UW'(DEPTH);

  always_comb begin
    state_d   = state_q;
    rdy_int   = 1'b0;
    req_int   = 1'b0;
    load_addr = 1'b0;
    case (state_q)
      LD_IDLE: begin
        rdy_int = 1'b1;
        if (instr_ld_valid) begin
          load_addr = 1'b1;
          state_d   = credit_ok ? LD_REQ : LD_STALL;
        end
      end
      LD_STALL: begin
        if (credit_ok) state_d = LD_REQ;
      end
      LD_REQ: begin
        req_int = 1'b1;
        // The address register frees up only when the current request is granted.
        rdy_int = mem_gnt;
        if (mem_gnt) begin
          if (instr_ld_valid) begin
            load_addr = 1'b1;
            state_d   = credit_after_gnt ? LD_REQ : LD_STALL;
          end else begin
            state_d = LD_IDLE;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  assign instr_ld_rdy = rdy_int & rst;
  assign mem_req      = req_int & rst;
  assign mem_addr     = addr_q;

  assign gnt_fire = mem_req & mem_gnt;
  // A response with nothing outstanding is stray and never enters the buffer.
  assign rsp_ok   = mem_rsp_valid & (outstanding_q != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= LD_IDLE;
      addr_q        <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_q + CW'(gnt_fire) - CW'(rsp_ok);
      if (load_addr) addr_q <= instr_ld_addr;
    end
  end

  pe_ld_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_ok),
    .push_data (mem_rsp_data),
    .pop       (pop),
    .pop_data  (ld_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign memory_unit_rdy = ~fifo_empty;

`ifdef PE_LD_UNIT_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_stall_cnt <= '0;
      fu_stall_cnt  <= '0;
    end else begin
      if (mem_req && !mem_gnt && (gnt_stall_cnt != '1))
        gnt_stall_cnt <= gnt_stall_cnt + 32'd1;
      if (memory_unit_rdy && !func_unit_rdy && (fu_stall_cnt != '1))
        fu_stall_cnt <= fu_stall_cnt + 32'd1;
    end
  end
`else
  // Stall counters are compiled out; nothing else changes.
`endif

  a_rsp_no_outstanding: assert property (@(posedge clk) disable iff (!rst)
    !(mem_rsp_valid && (outstanding_q == '0)))
    else $warning("pe_ld_unit_mem_side: read response with nothing outstanding, dropped");

  a_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_ok && fifo_full && !pop))
    else $warning("pe_ld_unit_mem_side: response pushed into full buffer, dropped");

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    (mem_req && !mem_gnt) |=> (mem_req && (mem_addr == $past(mem_addr))))
    else $warning("pe_ld_unit_mem_side: mem_addr/mem_req changed before grant");

  a_used_bound: assert property (@(posedge clk) disable iff (!rst)
    used <= UW'(DEPTH))
    else $warning("pe_ld_unit_mem_side: loads in flight exceed DEPTH");

endmodule

// File: tb/tb_pe_ld_unit_mem_side.sv
// Bench for pe_ld_unit_mem_side: directed load sequences against a queue-based model.
// Latency: n/a. Backpressure: bench drives gnt/func_unit_rdy patterns per scenario.
module tb_pe_ld_unit_mem_side;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_ld_valid;
  logic [15:0] instr_ld_addr;
  logic        instr_ld_rdy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        memory_unit_rdy;
  logic [31:0] ld_data;
  logic        func_unit_rdy;
`ifdef PE_LD_UNIT_PERF_CNT_EN
  logic [31:0] gnt_stall_cnt;
  logic [31:0] fu_stall_cnt;
`endif

  pe_ld_unit_mem_side #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_ld_valid  (instr_ld_valid),
    .instr_ld_addr   (instr_ld_addr),
    .instr_ld_rdy    (instr_ld_rdy),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_gnt         (mem_gnt),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .memory_unit_rdy (memory_unit_rdy),
    .ld_data         (ld_data),
    .func_unit_rdy   (func_unit_rdy)
`ifdef PE_LD_UNIT_PERF_CNT_EN
    ,
    .gnt_stall_cnt   (gnt_stall_cnt),
    .fu_stall_cnt    (fu_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] dat;
  } rsp_t;

  int nvec = 0;
  int nmis = 0;

  // Stimulus controls
  logic [15:0] iq[$];
  int          lat = 1;
  int          gnt_hold = 0;
  bit          fu_en = 1'b0;
  bit          stray = 1'b0;
  bit          rst_v = 1'b0;
  bit          chk_en = 1'b0;
  rsp_t        rq[$];

  // Model: accepted-not-granted addresses, granted count, buffered words
  logic [15:0] acc_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] popped[$];
  int          out_n = 0;
  int          cyc = 0;
  int          max_used = 0;
  int          m_gstall = 0;
  int          m_fstall = 0;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_addr = '0;

  function automatic logic [31:0] data_of(input logic [15:0] a);
    return 32'hDEADBEEF ^ {16'h0000, a ^ 16'h0010};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare outputs to the model, drive inputs, then account for the coming edge.
  task automatic step();
    rsp_t        r;
    logic [15:0] a;
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      chk("rdy_vs_model", 32'(memory_unit_rdy), 32'(buf_q.size() != 0));
      if (buf_q.size() != 0) chk("data_vs_model", ld_data, buf_q[0]);
      if (mem_req) begin
        if (acc_q.size() != 0) chk("req_addr_vs_model", 32'(mem_addr), 32'(acc_q[0]));
        else chk("req_without_load", 32'(mem_req), 32'd0);
        chk("credit_at_req", 32'(out_n + buf_q.size() < DEPTH), 32'd1);
      end
      if (prev_hold) begin
        chk("req_held", 32'(mem_req), 32'd1);
        chk("addr_held", 32'(mem_addr), 32'(prev_addr));
      end
`ifdef PE_LD_UNIT_PERF_CNT_EN
      chk("gnt_stall_cnt", gnt_stall_cnt, 32'(m_gstall));
      chk("fu_stall_cnt", fu_stall_cnt, 32'(m_fstall));
`endif
    end
    rst            = rst_v;
    instr_ld_valid = (iq.size() != 0);
    instr_ld_addr  = (iq.size() != 0) ? iq[0] : 16'h0;
    mem_gnt        = (gnt_hold == 0);
    if (mem_req && gnt_hold > 0) gnt_hold--;
    func_unit_rdy  = fu_en;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    if (stray) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h12345678;
      stray = 1'b0;
    end else if (rq.size() != 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = r.dat;
    end
    #1;
    if (!rst) begin
      acc_q.delete(); buf_q.delete(); rq.delete(); iq.delete();
      out_n = 0; m_gstall = 0; m_fstall = 0;
    end else begin
      if (mem_req && !mem_gnt) m_gstall++;
      if (memory_unit_rdy && !func_unit_rdy) m_fstall++;
      if (mem_rsp_valid && out_n > 0) begin
        out_n--;
        buf_q.push_back(mem_rsp_data);
      end
      if (mem_req && mem_gnt) begin
        if (acc_q.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL grant_without_load: got grant, expected none (t=%0t)", $time);
        end else begin
          a = acc_q.pop_front();
          chk("grant_addr", 32'(mem_addr), 32'(a));
          out_n++;
          r.due = cyc + lat;
          r.dat = data_of(a);
          rq.push_back(r);
        end
      end
      if (func_unit_rdy && memory_unit_rdy && buf_q.size() != 0) popped.push_back(buf_q.pop_front());
      if (instr_ld_valid && instr_ld_rdy) acc_q.push_back(iq.pop_front());
      if (out_n + buf_q.size() > max_used) max_used = out_n + buf_q.size();
    end
    prev_hold = rst && mem_req && !mem_gnt;
    prev_addr = mem_addr;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((iq.size() != 0 || acc_q.size() != 0 || out_n != 0 || buf_q.size() != 0 ||
            rq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  logic [7:0]  rec_req;
  logic [7:0]  rec_mur;
  logic [31:0] rec_dat;
  logic [15:0] rec_addr [8];
  bit          reached;

  initial begin
    rst = 1'b0; instr_ld_valid = 1'b0; instr_ld_addr = '0; mem_gnt = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; func_unit_rdy = 1'b0;

    // Reset
    rst_v = 1'b0;
    repeat (3) step();
    chk("rst_hold_ld_rdy", 32'(instr_ld_rdy), 32'd0);
    chk("rst_hold_mem_req", 32'(mem_req), 32'd0);
    chk("rst_hold_mu_rdy", 32'(memory_unit_rdy), 32'd0);
    rst_v = 1'b1;
    step();
    chk("rst_ld_rdy", 32'(instr_ld_rdy), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mu_rdy", 32'(memory_unit_rdy), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk_en = 1'b1;

    // Single load, L=3, immediate grant
    lat = 3; fu_en = 1'b1;
    iq.push_back(16'h0010);
    step();
    rec_dat = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      rec_req[k] = mem_req;
      rec_mur[k] = memory_unit_rdy;
      if (k == 4) rec_dat = ld_data;
    end
    chk("t1_req_pattern", 32'(rec_req), 32'h01);
    chk("t1_rdy_pattern", 32'(rec_mur), 32'h10);
    chk("t1_data", rec_dat, 32'hDEADBEEF);
    drain(50);

    // Grant withheld 4 cycles
    gnt_hold = 4;
    iq.push_back(16'h0010);
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      rec_req[k]  = mem_req;
      rec_addr[k] = mem_addr;
    end
    chk("t2_req_pattern", 32'(rec_req), 32'h1F);
    for (int k = 0; k < 5; k++) chk("t2_addr_stable", 32'(rec_addr[k]), 32'h0010);
    drain(50);
`ifdef PE_LD_UNIT_PERF_CNT_EN
    chk("t2_gnt_stall_cnt", gnt_stall_cnt, 32'd4);
`endif

    // Three back-to-back loads with consumer stalled
    lat = 1; fu_en = 1'b0; popped.delete();
    iq.push_back(16'h0100); iq.push_back(16'h0104); iq.push_back(16'h0108);
    repeat (8) step();
    chk("t3_stall_req", 32'(mem_req), 32'd0);
    chk("t3_stall_ld_rdy", 32'(instr_ld_rdy), 32'd0);
    chk("t3_head_rdy", 32'(memory_unit_rdy), 32'd1);
    chk("t3_head_data", ld_data, 32'hDEADBFFF);
    fu_en = 1'b1;
    step();
    fu_en = 1'b0;
    step();
    chk("t3_third_req", 32'(mem_req), 32'd1);
    chk("t3_third_addr", 32'(mem_addr), 32'h0108);
    chk("t3_second_data", ld_data, 32'hDEADBFFB);
    fu_en = 1'b1;
    drain(50);
    chk("t3_pop_count", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("t3_order0", popped[0], 32'hDEADBFFF);
      chk("t3_order1", popped[1], 32'hDEADBFFB);
      chk("t3_order2", popped[2], 32'hDEADBFF7);
    end

    // Ten loads, irregular consumer, pointers wrap several times
    lat = 2; popped.delete(); max_used = 0;
    for (int i = 0; i < 10; i++) iq.push_back(16'(16'h0200 + 4 * i));
    for (int n = 0; n < 200 && (iq.size() != 0 || acc_q.size() != 0 || out_n != 0 ||
                                buf_q.size() != 0); n++) begin
      fu_en = (n % 3 != 0);
      step();
    end
    fu_en = 1'b1;
    drain(50);
    chk("t4_pop_count", 32'(popped.size()), 32'd10);
    chk("t4_max_used", 32'(max_used), 32'd2);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      chk("t4_order", popped[i], data_of(16'(16'h0200 + 4 * i)));

    // Reset with one outstanding and one buffered, then a stray response
    fu_en = 1'b0; lat = 4; reached = 1'b0;
    iq.push_back(16'h0300); iq.push_back(16'h0304);
    for (int n = 0; n < 30 && !reached; n++) begin
      step();
      reached = (out_n == 1 && buf_q.size() == 1);
    end
    chk("t5_setup", 32'(reached), 32'd1);
    rst_v = 1'b0;
    step();
    rst_v = 1'b1;
    step();
    chk("t5_mu_rdy", 32'(memory_unit_rdy), 32'd0);
    chk("t5_mem_req", 32'(mem_req), 32'd0);
    chk("t5_ld_rdy", 32'(instr_ld_rdy), 32'd1);
    stray = 1'b1;
    repeat (3) step();
    chk("t5_stray_dropped", 32'(memory_unit_rdy), 32'd0);
    fu_en = 1'b1; lat = 1; popped.delete();
    iq.push_back(16'h0010);
    drain(50);
    chk("t5_after_reset_count", 32'(popped.size()), 32'd1);
    if (popped.size() == 1) chk("t5_after_reset_data", popped[0], 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_ld_unit_mem_side.md
Name: pe_ld_unit_mem_side

Overview:
- Memory-side end of the PE load flow-control handshake.
- Accepts load addresses from the PE decode stage and issues in-order read requests on a req/gnt memory port.
- Buffers returned data and presents it to the functional-unit flow control via memory_unit_rdy/ld_data.
- A word retires when the functional unit returns func_unit_rdy. Supports up to DEPTH loads in flight (requested + buffered).

Parameters:
- DATA_W, 32, width of load data word.
- ADDR_W, 16, width of load address.
- DEPTH, 2, max loads outstanding at memory plus loads buffered; power of 2, ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low; one clock domain only.
- instr_ld_valid  in  1  load instruction with address presented.
- instr_ld_addr  in  ADDR_W  load address.
- instr_ld_rdy  out  1  load instruction accepted when valid & rdy.
- mem_req  out  1  read request to memory.
- mem_addr  out  ADDR_W  read address; stable while mem_req & ~mem_gnt.
- mem_gnt  in  1  request accepted this cycle.
- mem_rsp_valid  in  1  read data returned, in request order, ≥1 cycle after grant.
- mem_rsp_data  in  DATA_W  read data.
- memory_unit_rdy  out  1  head word valid in buffer.
- ld_data  out  DATA_W  head word of buffer.
- func_unit_rdy  in  1  functional unit consumes head word this cycle.

Behaviour:
- Reset (rst==0 at posedge): FSM→IDLE; buffer empty; outstanding count=0; address register invalid.
  - All outputs 0 during and after reset until new activity: instr_ld_rdy=1 once rst=1, mem_req=0, mem_addr=0, memory_unit_rdy=0, ld_data=0.
  - Reset mid-operation discards in-flight and buffered loads.
- Credits: used = outstanding + occupancy, where 0 ≤ used ≤ DEPTH; credit_ok = (used < DEPTH).
- Request FSM:
  - IDLE: instr_ld_rdy=1. Accept → latch address → REQ if credit_ok, else STALL.
  - STALL: instr_ld_rdy=0, mem_req=0. Go to REQ when credit_ok.
  - REQ: mem_req=1, mem_addr held. On mem_gnt: outstanding++. Then IDLE, or, if instr_ld_valid is accepted in the same cycle (instr_ld_rdy = mem_gnt in REQ), latch the new address and stay in REQ/STALL per credits.
  - Once in REQ, mem_req is held until granted; credits only shrink on grant, so REQ never falls back to STALL.
- Response: mem_rsp_valid pushes mem_rsp_data at tail, outstanding--. Simultaneous grant and response leave outstanding unchanged.
- Output: memory_unit_rdy = ~empty (registered). ld_data = head entry. An empty buffer shows data the cycle after mem_rsp_valid; there is no combinational bypass.
- Pop: func_unit_rdy & memory_unit_rdy. func_unit_rdy while empty is ignored.
- Push and pop in the same cycle: occupancy unchanged, pointers advance; legal when full only via pop.
- Latency: accept at t → mem_req at t+1 → gnt at t+1 → rsp at t+1+L → memory_unit_rdy at t+2+L.
- Wrap-around: pointers are log2(DEPTH)+1 bits; full/empty determined by MSB compare.
- Errors (assertion, $warning; state not corrupted; offending response dropped):
  - mem_rsp_valid with outstanding==0.
  - push when full.
  - mem_addr change while mem_req & ~mem_gnt.
  - used > DEPTH.

Optional Feature:
- Macro PE_LD_UNIT_PERF_CNT_EN.
- When defined, adds output ports gnt_stall_cnt[31:0] and fu_stall_cnt[31:0].
  - gnt_stall_cnt counts cycles with mem_req & ~mem_gnt.
  - fu_stall_cnt counts cycles with memory_unit_rdy & ~func_unit_rdy.
  - Both saturate at 2^32-1 and clear on reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pe_ld_pkg: typedef enum logic[1:0] {LD_IDLE, LD_REQ, LD_STALL} ld_state_t; default DATA_W/ADDR_W constants.
- Sub-module pe_ld_rsp_fifo: DEPTH × DATA_W synchronous FIFO with push/pop/full/empty/count outputs, instantiated once.

Test Plan:
- Single load, addr 0x0010, gnt same cycle, rsp 0xDEADBEEF after L=3, func_unit_rdy high → memory_unit_rdy high at t+5 for exactly 1 cycle, ld_data=0xDEADBEEF.
- gnt withheld 4 cycles → mem_req and mem_addr=0x0010 stable for all 4; gnt_stall_cnt=4 when the macro is enabled.
- DEPTH=2, three back-to-back loads, func_unit_rdy=0 → third load held in STALL with mem_req=0. Raise func_unit_rdy → one pop, third request issues next cycle; data is returned in order.
- Buffer full with push and pop in the same cycle → occupancy stays 2, FIFO order preserved across pointer wrap over 10 loads.
- rst=0 with 1 outstanding and 1 buffered → next cycle memory_unit_rdy=0, mem_req=0, instr_ld_rdy=1. A stray mem_rsp_valid afterwards is dropped and triggers a warning.
